// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC controller.
// Stall-vector encodings, reset/enable levels and the PC alignment helper.
package pc_ctrl_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned STALL_W = 6;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    typedef logic [ADDR_W-1:0] inst_addr_t;

    // One hold bit per pipeline stage; pc is bit 0.
    typedef struct packed {
        logic wb;
        logic mem;
        logic ex;
        logic id;
        logic ifs;
        logic pc;
    } stall_t;

    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_IMEM = 6'b000011;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        S_RST,
        S_RUN,
        S_BPEND
    } state_e;

    function automatic inst_addr_t align_pc(input inst_addr_t a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Fetch-control bundle between the pipeline/imem side and pc_ctrl.
// master = the controller, slave = the stall/branch sources and imem.
interface pc_ctrl_if;
    import pc_ctrl_pkg::*;

    logic       stallreq_id;
    logic       stallreq_ex;
    logic       branch_flag;
    inst_addr_t branch_target;
    logic       flush_req;
    inst_addr_t flush_pc;
    logic       inst_ack;
    inst_addr_t pc;
    logic       ce;
    stall_t     stall;
    logic       flush;
    logic       fetch_valid;

    modport master (
        input  stallreq_id, stallreq_ex, branch_flag, branch_target,
        input  flush_req, flush_pc, inst_ack,
        output pc, ce, stall, flush, fetch_valid
    );

    modport slave (
        output stallreq_id, stallreq_ex, branch_flag, branch_target,
        output flush_req, flush_pc, inst_ack,
        input  pc, ce, stall, flush, fetch_valid
    );

endinterface

// File: rtl/pc_stall_enc.sv
// Priority encoder from stall/flush/ack requests to the stall vector
// and the IF/ID accept strobe.
module pc_stall_enc
    import pc_ctrl_pkg::*;
(
    input  logic   flush_req,
    input  logic   stallreq_ex,
    input  logic   stallreq_id,
    input  logic   inst_ack,
    output stall_t stall_c,
    output logic   fetch_valid_c
);

    // A flush overrides every stall source so the redirect is never held.
    always_comb begin
        stall_c = STALL_NONE;
        if (flush_req) begin
            stall_c = STALL_NONE;
        end else if (stallreq_ex) begin
            stall_c = STALL_EX;
        end else if (stallreq_id) begin
            stall_c = STALL_ID;
        end else if (!inst_ack) begin
            stall_c = STALL_IMEM;
        end
        fetch_valid_c = inst_ack & ~flush_req & ~stallreq_id & ~stallreq_ex;
    end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage PC sequencer: sequential fetch, branch redirect, flush and
// stall arbitration, with a one-deep pending-branch slot for stalled cycles.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter inst_addr_t  RESET_PC = '0,
    parameter int unsigned INC      = 4
) (
    input  logic        clk,
    input  logic        rst,
    pc_ctrl_if.master   bus
);

    state_e     state_q, state_d;
    inst_addr_t pc_q, pc_d;
    inst_addr_t btgt_q, btgt_d;
    logic       ce_q, ce_d;

    stall_t     enc_stall;
    logic       enc_fetch_valid;
    logic       run;

    pc_stall_enc u_stall_enc (
        .flush_req     (bus.flush_req),
        .stallreq_ex   (bus.stallreq_ex),
        .stallreq_id   (bus.stallreq_id),
        .inst_ack      (bus.inst_ack),
        .stall_c       (enc_stall),
        .fetch_valid_c (enc_fetch_valid)
    );

    assign run             = (state_q != S_RST);
    assign bus.pc          = pc_q;
    assign bus.ce          = ce_q;
    assign bus.stall       = run ? enc_stall : STALL_NONE;
    assign bus.flush       = run & bus.flush_req;
    assign bus.fetch_valid = run & enc_fetch_valid;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= S_RST;
            pc_q    <= RESET_PC;
            btgt_q  <= '0;
            ce_q    <= CHIP_DISABLE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            btgt_q  <= btgt_d;
            ce_q    <= ce_d;
        end
    end

    // S_BPEND is S_RUN with a captured branch waiting for the first unstalled edge.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        btgt_d  = btgt_q;
        ce_d    = ce_q;
        case (state_q)
            S_RST: begin
                state_d = S_RUN;
                ce_d    = CHIP_ENABLE;
            end
            S_RUN, S_BPEND: begin
                ce_d = CHIP_ENABLE;
                if (bus.flush_req) begin
                    pc_d    = align_pc(bus.flush_pc);
                    state_d = S_RUN;
                end else if (enc_stall.pc) begin
                    if (bus.branch_flag) begin
                        btgt_d  = align_pc(bus.branch_target);
                        state_d = S_BPEND;
                    end
                end else if (bus.branch_flag) begin
                    pc_d    = align_pc(bus.branch_target);
                    state_d = S_RUN;
                end else if (state_q == S_BPEND) begin
                    pc_d    = btgt_q;
                    state_d = S_RUN;
                end else begin
                    pc_d = align_pc(pc_q + ADDR_W'(INC));
                end
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pc_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk;
    logic rst;

    pc_ctrl_if bus ();

    pc_ctrl #(.RESET_PC(RST_PC), .INC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit          r_rst, r_sid, r_sex, r_bf, r_fr, r_ia;
    logic [31:0] r_bt, r_fp;

    bit          m_run;
    bit          m_bpend;
    logic [31:0] m_pc;
    logic [31:0] m_btgt;

    // Apply one cycle of inputs and wait until mid-cycle for sampling.
    task automatic drive(input bit r, input bit sid, input bit sex, input bit bf,
                         input logic [31:0] bt, input bit fr, input logic [31:0] fp,
                         input bit ia);
        r_rst = r; r_sid = sid; r_sex = sex; r_bf = bf; r_bt = bt;
        r_fr = fr; r_fp = fp; r_ia = ia;
        rst               = r;
        bus.stallreq_id   = sid;
        bus.stallreq_ex   = sex;
        bus.branch_flag   = bf;
        bus.branch_target = bt;
        bus.flush_req     = fr;
        bus.flush_pc      = fp;
        bus.inst_ack      = ia;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    endtask

    // Behavioural next-state: what the fetch address becomes at this edge.
    task automatic model_step();
        if (!r_rst) begin
            m_run = 0; m_bpend = 0; m_pc = RST_PC; m_btgt = 32'h0;
        end else if (!m_run) begin
            m_run = 1;
        end else if (r_fr) begin
            m_pc = r_fp & ~32'h3; m_bpend = 0;
        end else if (r_sex || r_sid || !r_ia) begin
            if (r_bf) begin m_bpend = 1; m_btgt = r_bt & ~32'h3; end
        end else if (r_bf) begin
            m_pc = r_bt & ~32'h3; m_bpend = 0;
        end else if (m_bpend) begin
            m_pc = m_btgt; m_bpend = 0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
        adv();
        drive(0, 1, 1, 1, 32'h44, 1, 32'h88, 0);
        checks++; if (bus.ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b want 0", bus.ce); end
        checks++; if (bus.pc !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.pc, RST_PC); end
        checks++; if (bus.stall !== 6'b000000) begin errors++; $display("FAIL reset_stall: got %b want 000000", bus.stall); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b want 0", bus.fetch_valid); end
        adv();
    endtask

    task automatic test_sequential();
        idle();
        checks++; if (bus.ce !== 1'b0) begin errors++; $display("FAIL release_ce_before: got %b want 0", bus.ce); end
        adv();
        idle();
        checks++; if (bus.ce !== 1'b1) begin errors++; $display("FAIL release_ce: got %b want 1", bus.ce); end
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL release_pc: got %h want 0", bus.pc); end
        checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL release_fv: got %b want 1", bus.fetch_valid); end
        for (int i = 1; i <= 3; i++) begin
            adv();
            idle();
            checks++; if (bus.pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, bus.pc, 32'(4 * i)); end
            checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_fv%0d: got %b want 1", i, bus.fetch_valid); end
        end
        adv();
    endtask

    task automatic test_stall_ex();
        drive(1, 0, 0, 1, 32'h10, 0, 32'h0, 1);
        adv();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 0, 32'h0, 0, 32'h0, 1);
            checks++; if (bus.stall !== 6'b001111) begin errors++; $display("FAIL ex_stall%0d: got %b want 001111", i, bus.stall); end
            checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL ex_pc%0d: got %h want 10", i, bus.pc); end
            checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL ex_fv%0d: got %b want 0", i, bus.fetch_valid); end
            checks++; if (bus.ce !== 1'b1) begin errors++; $display("FAIL ex_ce%0d: got %b want 1", i, bus.ce); end
            adv();
        end
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0, 1);
        checks++; if (bus.stall !== 6'b000111) begin errors++; $display("FAIL id_stall: got %b want 000111", bus.stall); end
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL id_fv: got %b want 0", bus.fetch_valid); end
        adv();
        idle();
        checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL ex_hold: got %h want 10", bus.pc); end
        adv();
        idle();
        checks++; if (bus.pc !== 32'h14) begin errors++; $display("FAIL ex_resume: got %h want 14", bus.pc); end
        adv();
    endtask

    task automatic test_imem_branch();
        drive(1, 0, 0, 1, 32'h20, 0, 32'h0, 1);
        adv();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, (i == 1), 32'h100, 0, 32'h0, 0);
            checks++; if (bus.stall !== 6'b000011) begin errors++; $display("FAIL imem_stall%0d: got %b want 000011", i, bus.stall); end
            checks++; if (bus.pc !== 32'h20) begin errors++; $display("FAIL imem_pc%0d: got %h want 20", i, bus.pc); end
            adv();
        end
        idle();
        checks++; if (bus.pc !== 32'h20) begin errors++; $display("FAIL imem_ack_pc: got %h want 20", bus.pc); end
        adv();
        idle();
        checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL imem_bpend: got %h want 100", bus.pc); end
        adv();
    endtask

    task automatic test_flush_over_stall();
        drive(1, 0, 0, 1, 32'h40, 0, 32'h0, 1);
        adv();
        drive(1, 0, 0, 1, 32'h300, 0, 32'h0, 0);
        adv();
        drive(1, 0, 1, 0, 32'h0, 1, 32'h180, 1);
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL flush_strobe: got %b want 1", bus.flush); end
        checks++; if (bus.stall !== 6'b000000) begin errors++; $display("FAIL flush_stall: got %b want 000000", bus.stall); end
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL flush_fv: got %b want 0", bus.fetch_valid); end
        adv();
        idle();
        checks++; if (bus.pc !== 32'h180) begin errors++; $display("FAIL flush_pc: got %h want 180", bus.pc); end
        adv();
        idle();
        checks++; if (bus.pc !== 32'h184) begin errors++; $display("FAIL flush_bpend_clr: got %h want 184", bus.pc); end
        adv();
    endtask

    task automatic test_wrap_align();
        drive(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1);
        adv();
        idle();
        checks++; if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h want fffffffc", bus.pc); end
        adv();
        drive(1, 0, 0, 1, 32'h203, 0, 32'h0, 1);
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", bus.pc); end
        adv();
        drive(1, 0, 0, 0, 32'h0, 1, 32'h187, 1);
        checks++; if (bus.pc !== 32'h200) begin errors++; $display("FAIL align_branch: got %h want 200", bus.pc); end
        adv();
        idle();
        checks++; if (bus.pc !== 32'h184) begin errors++; $display("FAIL align_flush: got %h want 184", bus.pc); end
        adv();
    endtask

    task automatic test_reset_mid_pending();
        drive(1, 0, 0, 1, 32'h80, 0, 32'h0, 1);
        adv();
        drive(1, 0, 0, 1, 32'h500, 0, 32'h0, 0);
        adv();
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
        adv();
        drive(0, 0, 1, 0, 32'h0, 1, 32'h44, 1);
        checks++; if (bus.pc !== RST_PC) begin errors++; $display("FAIL mid_rst_pc: got %h want %h", bus.pc, RST_PC); end
        checks++; if (bus.ce !== 1'b0) begin errors++; $display("FAIL mid_rst_ce: got %b want 0", bus.ce); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL mid_rst_flush: got %b want 0", bus.flush); end
        adv();
        idle();
        adv();
        idle();
        checks++; if (bus.pc !== 32'h0 || bus.ce !== 1'b1) begin errors++; $display("FAIL mid_rel: got pc=%h ce=%b want pc=0 ce=1", bus.pc, bus.ce); end
        adv();
        idle();
        checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL mid_no_stale: got %h want 4", bus.pc); end
        adv();
        idle();
        checks++; if (bus.pc !== 32'h8) begin errors++; $display("FAIL mid_seq: got %h want 8", bus.pc); end
        adv();
    endtask

    task automatic test_random();
        logic [5:0] exp_stall;
        bit         exp_fv, exp_flush;
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) != 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0),
                  $urandom(),
                  ($urandom_range(0, 9) == 0),
                  $urandom(),
                  ($urandom_range(0, 4) != 0));
            if (!m_run || r_fr) exp_stall = 6'b000000;
            else if (r_sex)     exp_stall = 6'b001111;
            else if (r_sid)     exp_stall = 6'b000111;
            else if (!r_ia)     exp_stall = 6'b000011;
            else                exp_stall = 6'b000000;
            exp_fv    = m_run && r_ia && !r_fr && !r_sid && !r_sex;
            exp_flush = m_run && r_fr;
            checks++; if (bus.pc !== m_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h want %h", n, bus.pc, m_pc); end
            checks++; if (bus.ce !== m_run) begin errors++; $display("FAIL rnd_ce@%0d: got %b want %b", n, bus.ce, m_run); end
            checks++; if (bus.stall !== exp_stall) begin errors++; $display("FAIL rnd_stall@%0d: got %b want %b", n, bus.stall, exp_stall); end
            checks++; if (bus.flush !== exp_flush) begin errors++; $display("FAIL rnd_flush@%0d: got %b want %b", n, bus.flush, exp_flush); end
            checks++; if (bus.fetch_valid !== exp_fv) begin errors++; $display("FAIL rnd_fv@%0d: got %b want %b", n, bus.fetch_valid, exp_fv); end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_ex();
        test_imem_branch();
        test_flush_over_stall();
        test_wrap_align();
        test_reset_mid_pending();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
